// File: rtl/ram_rd_pkg.sv
// ram_rd_pkg: shared state encoding and buffer/credit constants for the RAM burst reader.
package ram_rd_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} rd_state_t;
    localparam int RD_BUF_DEPTH = 2;
    localparam int RD_CREDIT    = 2;
endpackage

// File: rtl/ram_burst_reader_if.sv
// ram_burst_reader_if: valid/ready beat stream with data and last marker.
interface ram_burst_reader_if #(parameter int DWIDTH = 8);
    logic              valid;
    logic              ready;
    logic [DWIDTH-1:0] data;
    logic              last;
    modport master (output valid, data, last, input ready);
    modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/ram_rd_skid.sv
// ram_rd_skid: 2-entry valid/ready buffer carrying a data word and its last tag.
module ram_rd_skid
    import ram_rd_pkg::*;
#(
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DWIDTH-1:0] din,
    input  logic              lin,
    input  logic              flush,
    input  logic              ready,
    output logic [1:0]        count,
    output logic              valid,
    output logic [DWIDTH-1:0] data,
    output logic              last
);
    logic [DWIDTH:0] mem [RD_BUF_DEPTH];
    logic            rp, wp, pop;

    assign valid = count != 2'd0;
    assign pop   = valid && ready;
    assign {last, data} = mem[rp];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem   <= '{default: '0};
            rp    <= 1'b0;
            wp    <= 1'b0;
            count <= 2'd0;
        end else if (flush) begin
            rp    <= 1'b0;
            wp    <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                mem[wp] <= {lin, din};
                wp      <= ~wp;
            end
            if (pop) rp <= ~rp;
            count <= count + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: rtl/ram_burst_reader.sv
// ram_burst_reader: issues RAM reads for a burst and streams the words out with backpressure,
// absorbing the one-cycle read latency in a 2-entry buffer.
module ram_burst_reader
    import ram_rd_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AWIDTH-1:0] start_addr,
    input  logic [AWIDTH:0]   length,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [AWIDTH-1:0] raddr,
    input  logic [DWIDTH-1:0] rdata,
    ram_burst_reader_if.master m
);
    rd_state_t         state;
    logic [AWIDTH-1:0] addr;
    logic [AWIDTH:0]   rem;
    logic              pending, pend_last, issue, pop, flush, final_issue;
    logic [1:0]        count;

    assign busy  = state != IDLE;
    assign raddr = addr;
    assign pop   = m.valid && m.ready;
    assign flush = abort && busy;
    // A pop in the same cycle frees a slot, so issuing at full credit cannot overflow.
    assign issue = state == RUN && !abort && rem != '0 &&
                   (({1'b0, count} + {2'b0, pending}) < 3'(RD_CREDIT) || pop);
    assign final_issue = issue && rem == (AWIDTH+1)'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            rem       <= '0;
            pending   <= 1'b0;
            pend_last <= 1'b0;
            done      <= 1'b0;
        end else begin
            done      <= 1'b0;
            pending   <= issue;
            pend_last <= final_issue;
            if (issue) begin
                addr <= addr + AWIDTH'(1);
                rem  <= rem - (AWIDTH+1)'(1);
            end
            case (state)
                IDLE: if (start) begin
                    if (length == '0) done <= 1'b1;
                    else begin
                        addr  <= start_addr;
                        rem   <= length;
                        state <= RUN;
                    end
                end
                RUN: if (abort) state <= IDLE;
                     else if (final_issue) state <= DRAIN;
                // Finish as the last beat leaves so done lands the cycle after its handshake.
                DRAIN: if (abort) state <= IDLE;
                       else if (!pending && (count == 2'd0 || (count == 2'd1 && pop))) begin
                           done  <= 1'b1;
                           state <= IDLE;
                       end
                default: state <= IDLE;
            endcase
        end
    end

    ram_rd_skid #(.DWIDTH(DWIDTH)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (pending),
        .din   (rdata),
        .lin   (pend_last),
        .flush (flush),
        .ready (m.ready),
        .count (count),
        .valid (m.valid),
        .data  (m.data),
        .last  (m.last)
    );
endmodule
